// File: rtl/if_ctrl_fsm.sv
// Multi-cycle control FSM for a simple five-state CPU datapath.
// Decodes a latched opcode/func pair and sequences FETCH, DECODE, EXEC,
// MEM and WB. It also guards data-memory waits with a saturating timeout.
module if_ctrl_fsm #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        Mem_Ready,
  output logic        PC_sel,
  output logic        PC_LdEn,
  output logic        IR_LdEn,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        ALU_Bin_sel,
  output logic [3:0]  ALU_func,
  output logic [1:0]  ImmExt,
  output logic        MEM_WrEn,
  output logic        ByteOp,
  output logic        Instr_Done,
  output logic        Mem_Timeout
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT_MAX);

  state_t      state_q, state_d;
  logic [5:0]  opcode_q;
  logic [5:0]  func_q;
  logic [3:0]  wait_cnt_q;
  logic        timeout_q;
  logic        timeout_set;

  // Immediate and register fields are consumed by the datapath, not by control.
  logic unused_instr_bits;
  assign unused_instr_bits = ^Instr[25:6];

  // Opcode class decode, driven only from the latched opcode copy.
  logic is_rtype, is_imm, is_branch, is_load, is_store, is_legal;
  logic is_li, is_lui, is_addi, is_andi, is_ori;
  logic is_b, is_beq, is_bne, is_lb, is_lw, is_sb, is_sw;

  assign is_rtype  = (opcode_q == 6'b100000);
  assign is_li     = (opcode_q == 6'b111000);
  assign is_lui    = (opcode_q == 6'b111001);
  assign is_addi   = (opcode_q == 6'b110000);
  assign is_andi   = (opcode_q == 6'b110010);
  assign is_ori    = (opcode_q == 6'b110011);
  assign is_b      = (opcode_q == 6'b111111);
  assign is_beq    = (opcode_q == 6'b010000);
  assign is_bne    = (opcode_q == 6'b010001);
  assign is_lb     = (opcode_q == 6'b000011);
  assign is_lw     = (opcode_q == 6'b001111);
  assign is_sb     = (opcode_q == 6'b000111);
  assign is_sw     = (opcode_q == 6'b011111);
  assign is_imm    = is_li | is_lui | is_addi | is_andi | is_ori;
  assign is_branch = is_b | is_beq | is_bne;
  assign is_load   = is_lb | is_lw;
  assign is_store  = is_sb | is_sw;
  assign is_legal  = is_rtype | is_imm | is_branch | is_load | is_store;

  // Per-instruction operand controls, held constant from EXEC through WB.
  logic       bin_sel_c;
  logic [1:0] immext_c;
  logic       byteop_c;
  logic [3:0] alu_func_c;

  assign bin_sel_c = is_imm | is_load | is_store;
  assign byteop_c  = is_lb | is_sb;

  // Immediate-extension mode and ALU operation for the latched instruction.
  always_comb begin
    immext_c   = 2'b00;
    alu_func_c = 4'b0000;
    if (is_andi || is_ori) immext_c = 2'b01;
    else if (is_lui)       immext_c = 2'b10;
    else if (is_branch)    immext_c = 2'b11;
    if (is_rtype) begin
      if (func_q[5:3] == 3'b110) alu_func_c = {1'b0, func_q[2:0]};
    end else if (is_beq || is_bne) begin
      alu_func_c = 4'b0001;
    end else if (is_andi) begin
      alu_func_c = 4'b0010;
    end else if (is_ori) begin
      alu_func_c = 4'b0011;
    end
  end

  // Raw (pre-reset-gating) control outputs.
  logic       pc_sel_c, pc_ld_c, ir_ld_c, rf_wr_c, rf_sel_c;
  logic       bin_sel_o_c, mem_wr_c, byteop_o_c, done_c;
  logic [3:0] alu_func_o_c;
  logic [1:0] immext_o_c;

  // Next-state and output logic; every output defaults to 0.
  always_comb begin
    state_d      = state_q;
    pc_sel_c     = 1'b0;
    pc_ld_c      = 1'b0;
    ir_ld_c      = 1'b0;
    rf_wr_c      = 1'b0;
    rf_sel_c     = 1'b0;
    bin_sel_o_c  = 1'b0;
    alu_func_o_c = 4'b0000;
    immext_o_c   = 2'b00;
    mem_wr_c     = 1'b0;
    byteop_o_c   = 1'b0;
    done_c       = 1'b0;
    timeout_set  = 1'b0;
    case (state_q)
      FETCH: begin
        ir_ld_c = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        if (is_legal) begin
          state_d = EXEC;
        end else begin
          pc_ld_c = 1'b1;
          done_c  = 1'b1;
          state_d = FETCH;
        end
      end
      EXEC: begin
        alu_func_o_c = alu_func_c;
        bin_sel_o_c  = bin_sel_c;
        immext_o_c   = immext_c;
        byteop_o_c   = byteop_c;
        if (is_branch) begin
          pc_ld_c  = 1'b1;
          done_c   = 1'b1;
          pc_sel_c = is_b | (is_beq & Zero) | (is_bne & ~Zero);
          state_d  = FETCH;
        end else if (is_load || is_store) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        bin_sel_o_c = bin_sel_c;
        immext_o_c  = immext_c;
        byteop_o_c  = byteop_c;
        if (Mem_Ready) begin
          mem_wr_c = is_store;
          if (is_store) begin
            pc_ld_c = 1'b1;
            done_c  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (wait_cnt_q == WAIT_MAX) begin
          // Abandon the access: no memory or RF write, fall through to PC+4.
          timeout_set = 1'b1;
          pc_ld_c     = 1'b1;
          done_c      = 1'b1;
          state_d     = FETCH;
        end else begin
          mem_wr_c = is_store;
        end
      end
      WB: begin
        bin_sel_o_c = bin_sel_c;
        immext_o_c  = immext_c;
        byteop_o_c  = byteop_c;
        rf_wr_c     = 1'b1;
        rf_sel_c    = is_load;
        pc_ld_c     = 1'b1;
        done_c      = 1'b1;
        state_d     = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Capture opcode/func when leaving FETCH; decode never looks at Instr again.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      opcode_q <= 6'd0;
      func_q   <= 6'd0;
    end else if (state_q == FETCH) begin
      opcode_q <= Instr[31:26];
      func_q   <= Instr[5:0];
    end
  end

  // MEM wait counter: zero on entry to MEM, saturates at 15.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                  wait_cnt_q <= 4'd0;
    else if (state_q != MEM)     wait_cnt_q <= 4'd0;
    else if (wait_cnt_q != 4'hF) wait_cnt_q <= wait_cnt_q + 4'd1;
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)           timeout_q <= 1'b0;
    else if (timeout_set) timeout_q <= 1'b1;
  end

  // Reset gates every combinational output so they drop to 0 immediately.
  assign PC_sel        = pc_sel_c    & Reset;
  assign PC_LdEn       = pc_ld_c     & Reset;
  assign IR_LdEn       = ir_ld_c     & Reset;
  assign RF_WrEn       = rf_wr_c     & Reset;
  assign RF_WrData_sel = rf_sel_c    & Reset;
  assign ALU_Bin_sel   = bin_sel_o_c & Reset;
  assign ALU_func      = alu_func_o_c & {4{Reset}};
  assign ImmExt        = immext_o_c  & {2{Reset}};
  assign MEM_WrEn      = mem_wr_c    & Reset;
  assign ByteOp        = byteop_o_c  & Reset;
  assign Instr_Done    = done_c      & Reset;
  assign Mem_Timeout   = timeout_q;

endmodule

// File: tb/tb_if_ctrl_fsm.sv
// Scoreboard bench for if_ctrl_fsm: the driver pushes one expected output
// vector per cycle, and the monitor pops and compares it on the falling edge.
module tb_if_ctrl_fsm;

  logic        Clk;
  logic        Reset;
  logic [31:0] Instr;
  logic        Zero;
  logic        Mem_Ready;
  logic        PC_sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, ALU_Bin_sel;
  logic [3:0]  ALU_func;
  logic [1:0]  ImmExt;
  logic        MEM_WrEn, ByteOp, Instr_Done, Mem_Timeout;

  if_ctrl_fsm #(.MEM_WAIT_MAX(15)) dut (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .Zero(Zero), .Mem_Ready(Mem_Ready),
    .PC_sel(PC_sel), .PC_LdEn(PC_LdEn), .IR_LdEn(IR_LdEn), .RF_WrEn(RF_WrEn),
    .RF_WrData_sel(RF_WrData_sel), .ALU_Bin_sel(ALU_Bin_sel), .ALU_func(ALU_func),
    .ImmExt(ImmExt), .MEM_WrEn(MEM_WrEn), .ByteOp(ByteOp), .Instr_Done(Instr_Done),
    .Mem_Timeout(Mem_Timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_q[$];
  logic [15:0] msk_q[$];
  string       name_q[$];

  // Bit order: [15]PC_sel [14]PC_LdEn [13]IR_LdEn [12]RF_WrEn [11]RF_WrData_sel
  // [10]ALU_Bin_sel [9:6]ALU_func [5:4]ImmExt [3]MEM_WrEn [2]ByteOp [1]Instr_Done [0]Mem_Timeout
  function automatic logic [15:0] ov(input logic pcsel, input logic pcld, input logic irld,
                                     input logic rfwr, input logic rfsel, input logic bsel,
                                     input logic [3:0] fn, input logic [1:0] ie, input logic mwr,
                                     input logic bop, input logic done, input logic to);
    return {pcsel, pcld, irld, rfwr, rfsel, bsel, fn, ie, mwr, bop, done, to};
  endfunction

  localparam logic [15:0] ALL   = 16'hFFFF;
  localparam logic [31:0] BOGUS = 32'hFC00_0000;  // opcode of 'b'; must be ignored after FETCH

  logic to;  // expected Mem_Timeout level

  // One clock cycle: apply inputs just after the rising edge and queue the expectation.
  task automatic step(input logic rst, input logic [31:0] ins, input logic z, input logic mr,
                      input logic [15:0] e, input logic [15:0] m, input string nm);
    @(posedge Clk);
    #1;
    Reset     = rst;
    Instr     = ins;
    Zero      = z;
    Mem_Ready = mr;
    exp_q.push_back(e);
    msk_q.push_back(m);
    name_q.push_back(nm);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation on each falling edge.
  initial begin
    logic [15:0] got, e, m;
    string nm;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        m  = msk_q.pop_front();
        nm = name_q.pop_front();
        got = {PC_sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, ALU_Bin_sel, ALU_func,
               ImmExt, MEM_WrEn, ByteOp, Instr_Done, Mem_Timeout};
        n_tests++;
        if (((got ^ e) & m) != 16'h0) begin
          n_fail++;
          $display("FAIL %s: outputs got=%04h expected=%04h (mask %04h)", nm, got, e, m);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0; Instr = 32'h0; Zero = 1'b0; Mem_Ready = 1'b0;
    to = 1'b0;

    // Held in reset: everything 0.
    step(0, 32'h0, 0, 0, 16'h0, ALL, "reset_a");
    step(0, 32'h0, 0, 0, 16'h0, ALL, "reset_b");

    // addi, Zero=1 must not matter.
    step(1, {6'b110000, 20'h0, 6'h0}, 1, 0, ov(0,0,1,0,0,0,4'h0,2'b00,0,0,0,to), ALL, "addi_c1");
    step(1, BOGUS, 1, 0, ov(0,0,0,0,0,0,4'h0,2'b00,0,0,0,to), ALL, "addi_c2");
    step(1, BOGUS, 1, 0, ov(0,0,0,0,0,1,4'h0,2'b00,0,0,0,to), ALL, "addi_c3");
    step(1, BOGUS, 1, 0, ov(0,1,0,1,0,1,4'h0,2'b00,0,0,1,to), ALL, "addi_c4");

    // beq taken.
    step(1, {6'b010000, 26'h0}, 1, 0, ov(0,0,1,0,0,0,4'h0,2'b00,0,0,0,to), ALL, "beqT_c1");
    step(1, BOGUS, 1, 0, ov(0,0,0,0,0,0,4'h0,2'b00,0,0,0,to), ALL, "beqT_c2");
    step(1, BOGUS, 1, 0, ov(1,1,0,0,0,0,4'h1,2'b11,0,0,1,to), ALL, "beqT_c3");

    // beq not taken.
    step(1, {6'b010000, 26'h0}, 0, 0, ov(0,0,1,0,0,0,4'h0,2'b00,0,0,0,to), ALL, "beqN_c1");
    step(1, BOGUS, 0, 0, ov(0,0,0,0,0,0,4'h0,2'b00,0,0,0,to), ALL, "beqN_c2");
    step(1, BOGUS, 0, 0, ov(0,1,0,0,0,0,4'h1,2'b11,0,0,1,to), ALL, "beqN_c3");

    // ori: zero-fill immediate, ALU op 0011.
    step(1, {6'b110011, 26'h0}, 0, 0, ov(0,0,1,0,0,0,4'h0,2'b00,0,0,0,to), ALL, "ori_c1");
    step(1, BOGUS, 0, 0, ov(0,0,0,0,0,0,4'h0,2'b00,0,0,0,to), ALL, "ori_c2");
    step(1, BOGUS, 0, 0, ov(0,0,0,0,0,1,4'h3,2'b01,0,0,0,to), ALL, "ori_c3");
    step(1, BOGUS, 0, 0, ov(0,1,0,1,0,1,4'h0,2'b01,0,0,1,to), ALL, "ori_c4");

    // lw: Mem_Ready low for two MEM cycles, high on the third.
    step(1, {6'b001111, 26'h0}, 0, 0, ov(0,0,1,0,0,0,4'h0,2'b00,0,0,0,to), ALL, "lw_c1");
    step(1, BOGUS, 0, 0, ov(0,0,0,0,0,0,4'h0,2'b00,0,0,0,to), ALL, "lw_c2");
    step(1, BOGUS, 0, 0, ov(0,0,0,0,0,1,4'h0,2'b00,0,0,0,to), ALL, "lw_c3");
    step(1, BOGUS, 0, 0, ov(0,0,0,0,0,1,4'h0,2'b00,0,0,0,to), ALL, "lw_mem1");
    step(1, BOGUS, 0, 0, ov(0,0,0,0,0,1,4'h0,2'b00,0,0,0,to), ALL, "lw_mem2");
    step(1, BOGUS, 0, 1, ov(0,0,0,0,0,1,4'h0,2'b00,0,0,0,to), ALL, "lw_mem3");
    step(1, BOGUS, 0, 0, ov(0,1,0,1,1,1,4'h0,2'b00,0,0,1,to), ALL, "lw_wb");

    // lb with immediate Mem_Ready: ByteOp held EXEC..WB.
    step(1, {6'b000011, 26'h0}, 0, 1, ov(0,0,1,0,0,0,4'h0,2'b00,0,0,0,to), ALL, "lb_c1");
    step(1, BOGUS, 0, 1, ov(0,0,0,0,0,0,4'h0,2'b00,0,0,0,to), ALL, "lb_c2");
    step(1, BOGUS, 0, 1, ov(0,0,0,0,0,1,4'h0,2'b00,0,1,0,to), ALL, "lb_c3");
    step(1, BOGUS, 0, 1, ov(0,0,0,0,0,1,4'h0,2'b00,0,1,0,to), ALL, "lb_mem");
    step(1, BOGUS, 0, 0, ov(0,1,0,1,1,1,4'h0,2'b00,0,1,1,to), ALL, "lb_wb");

    // Illegal opcode 000000: done in DECODE.
    step(1, 32'h0000_0000, 0, 0, ov(0,0,1,0,0,0,4'h0,2'b00,0,0,0,to), ALL, "ill_c1");
    step(1, BOGUS, 0, 0, ov(0,1,0,0,0,0,4'h0,2'b00,0,0,1,to), ALL, "ill_c2");

    // sw with Mem_Ready stuck low: 15 write cycles, then timeout exit.
    step(1, {6'b011111, 26'h0}, 0, 0, ov(0,0,1,0,0,0,4'h0,2'b00,0,0,0,to), ALL, "sw_c1");
    step(1, BOGUS, 0, 0, ov(0,0,0,0,0,0,4'h0,2'b00,0,0,0,to), ALL, "sw_c2");
    step(1, BOGUS, 0, 0, ov(0,0,0,0,0,1,4'h0,2'b00,0,0,0,to), ALL, "sw_c3");
    for (int i = 0; i < 15; i++)
      step(1, BOGUS, 0, 0, ov(0,0,0,0,0,1,4'h0,2'b00,1,0,0,to), ALL, $sformatf("sw_wait%0d", i));
    step(1, BOGUS, 0, 0, ov(0,1,0,0,0,1,4'h0,2'b00,0,0,0,to), ALL & ~16'h0002, "sw_timeout");
    to = 1'b1;

    // R-type (func 110010 -> ALU 0010), reset asserted in WB.
    step(1, {6'b100000, 20'h0, 6'b110010}, 0, 0, ov(0,0,1,0,0,0,4'h0,2'b00,0,0,0,to), ALL, "rt_c1");
    step(1, BOGUS, 0, 0, ov(0,0,0,0,0,0,4'h0,2'b00,0,0,0,to), ALL, "rt_c2");
    step(1, BOGUS, 0, 0, ov(0,0,0,0,0,0,4'h2,2'b00,0,0,0,to), ALL, "rt_c3");
    to = 1'b0;
    step(0, BOGUS, 0, 0, 16'h0, ALL, "rt_wb_reset");
    step(0, BOGUS, 0, 0, 16'h0, ALL, "rt_reset_hold");

    // Release: FETCH immediately, then a full addi.
    step(1, {6'b110000, 26'h0}, 0, 0, ov(0,0,1,0,0,0,4'h0,2'b00,0,0,0,to), ALL, "post_c1");
    step(1, BOGUS, 0, 0, ov(0,0,0,0,0,0,4'h0,2'b00,0,0,0,to), ALL, "post_c2");
    step(1, BOGUS, 0, 0, ov(0,0,0,0,0,1,4'h0,2'b00,0,0,0,to), ALL, "post_c3");
    step(1, BOGUS, 0, 0, ov(0,1,0,1,0,1,4'h0,2'b00,0,0,1,to), ALL, "post_c4");
    step(1, BOGUS, 0, 0, ov(0,0,1,0,0,0,4'h0,2'b00,0,0,0,to), ALL, "post_fetch");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
